frame_buffer_arbiter: RTL and testbench

Shares the single-port 8-bit frame-buffer RAM between the VGA pixel-fetch path and the image-filter engine. Fixed priority: the display fetch always wins; the filter is served in horizontal/vertical blanking and in any other cycle without a display request. The block drives the RAM command registers and pipelines a read-owner tag so each returned byte reaches the requester that asked for it. Placed between the display interface, the filter engine and the frame-buffer RAM.

---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_tag_pipe.sv | 30 +++
 rtl/frame_buffer_arbiter.sv | 132 +++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the frame-buffer arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default byte-address and pixel widths (640x480, 8-bit)
//   owner_e                 : owner code, used by the arbiter state register and the read-tag pipe
package fb_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_FLT  = 2'd2
  } owner_e;

endpackage

// File: rtl/fb_tag_pipe.sv
// fb_tag_pipe: DEPTH-stage shift register of read-owner tags.
//   clk     in  clock
//   reset   in  asynchronous active-low reset, clears every stage to OWN_NONE
//   tag_in  in  owner of the command being registered this edge (OWN_NONE for writes/idle)
//   tag_out out owner of the byte currently on the RAM read-data bus
module fb_tag_pipe
  import fb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  owner_e tag_in,
  output owner_e tag_out
);

  owner_e stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares a single-port frame-buffer RAM between the VGA
// pixel fetch (fixed highest priority) and the image-filter engine.
//   clk, reset                          clock, asynchronous active-low reset
//   vga_req/vga_addr                    display fetch, one byte per cycle while high
//   vga_data/vga_valid                  returned display byte (held) and its one-cycle strobe
//   flt_req/flt_we/flt_addr/flt_wdata   filter access, held stable until flt_gnt
//   flt_gnt                             combinational accept strobe
//   flt_rdata/flt_rvalid                returned filter read byte (held) and its strobe
//   mem_addr/mem_we/mem_wdata           registered RAM command
//   mem_rdata                           RAM read data, RD_LAT cycles after mem_addr
// Optional build macro FB_ARB_STATS_EN adds stat_clr, stat_flt_wait and
// stat_vga_reads (16-bit saturating counters, clear has priority).
//
// state    | meaning
// OWN_NONE | no RAM command issued this cycle (IDLE)
// OWN_VGA  | display read issued this cycle
// OWN_FLT  | filter read or write issued this cycle
module frame_buffer_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              flt_req,
  input  logic              flt_we,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [DATA_W-1:0] flt_wdata,
  output logic              flt_gnt,
  output logic [DATA_W-1:0] flt_rdata,
  output logic              flt_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef FB_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_flt_wait,
  output logic [15:0]       stat_vga_reads,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e              state;
  owner_e              tag_in;
  owner_e              tag_out;
  logic [DATA_W-1:0]   vga_hold;
  logic [DATA_W-1:0]   flt_hold;

  // Gated with reset so the filter never sees an accept while the block is held in reset.
  assign flt_gnt = flt_req & ~vga_req & reset;

  always_comb begin
    tag_in = OWN_NONE;
    if (vga_req)               tag_in = OWN_VGA;
    else if (flt_req && !flt_we) tag_in = OWN_FLT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= OWN_NONE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (vga_req) begin
        state    <= OWN_VGA;
        mem_addr <= vga_addr;
      end else if (flt_req) begin
        state    <= OWN_FLT;
        mem_addr <= flt_addr;
        mem_we   <= flt_we;
        if (flt_we) mem_wdata <= flt_wdata;
      end else begin
        state <= OWN_NONE;
      end
    end
  end

  // Only a filter command may carry a write.
  a_we_owner : assert property (@(posedge clk) disable iff (!reset)
                                (state != OWN_FLT) |-> !mem_we);

  fb_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // The returning byte is forwarded straight from the RAM in its valid cycle and
  // captured so the port keeps showing it until the next return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_hold <= '0;
      flt_hold <= '0;
    end else begin
      if (tag_out == OWN_VGA) vga_hold <= mem_rdata;
      if (tag_out == OWN_FLT) flt_hold <= mem_rdata;
    end
  end

  assign vga_valid  = (tag_out == OWN_VGA);
  assign flt_rvalid = (tag_out == OWN_FLT);
  assign vga_data   = vga_valid  ? mem_rdata : vga_hold;
  assign flt_rdata  = flt_rvalid ? mem_rdata : flt_hold;

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_flt_wait  <= '0;
      stat_vga_reads <= '0;
    end else if (stat_clr) begin
      stat_flt_wait  <= '0;
      stat_vga_reads <= '0;
    end else begin
      // A waiting filter is exactly a filter request overlapping a display request.
      if (flt_req && vga_req && stat_flt_wait != 16'hFFFF)
        stat_flt_wait <= stat_flt_wait + 16'd1;
      if (vga_req && stat_vga_reads != 16'hFFFF)
        stat_vga_reads <= stat_vga_reads + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
module tb_frame_buffer_arbiter;

  localparam int AW     = 19;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;
  localparam int LAT    = RD_LAT + 1;

  logic          clk;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  logic          flt_req;
  logic          flt_we;
  logic [AW-1:0] flt_addr;
  logic [DW-1:0] flt_wdata;
  logic          flt_gnt;
  logic [DW-1:0] flt_rdata;
  logic          flt_rvalid;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef FB_ARB_STATS_EN
  logic          stat_clr;
  logic [15:0]   stat_flt_wait;
  logic [15:0]   stat_vga_reads;
`endif

  frame_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_data   (vga_data),
    .vga_valid  (vga_valid),
    .flt_req    (flt_req),
    .flt_we     (flt_we),
    .flt_addr   (flt_addr),
    .flt_wdata  (flt_wdata),
    .flt_gnt    (flt_gnt),
    .flt_rdata  (flt_rdata),
    .flt_rvalid (flt_rvalid),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
`ifdef FB_ARB_STATS_EN
    .stat_clr       (stat_clr),
    .stat_flt_wait  (stat_flt_wait),
    .stat_vga_reads (stat_vga_reads),
`endif
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model: write-first, preloaded with data = addr[7:0]
  logic [DW-1:0] ram_w [int];
  logic [DW-1:0] rd_pipe [RD_LAT];

  function automatic logic [DW-1:0] ram_rd(input int a);
    logic [31:0] t;
    t = a;
    return ram_w.exists(a) ? ram_w[a] : t[7:0];
  endfunction

  always @(posedge clk) begin
    if (mem_we === 1'b1) ram_w[int'(mem_addr)] = mem_wdata;
    rd_pipe[0] <= ram_rd(int'(mem_addr));
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------- reference model: per-cycle grant rule, memory image, return schedule
  int            n_cmp, n_bad;
  int            cyc;
  logic [DW-1:0] ref_mem [int];
  bit            exp_vv [int];
  logic [DW-1:0] exp_vd [int];
  bit            exp_fv [int];
  logic [DW-1:0] exp_fd [int];
  logic [DW-1:0] hold_v, hold_f;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_wdata;
  int            e_wait, e_vrd;
  bit            stat_clr_drv;
  int            pulses_v, pulses_f, pulses_we, gnts, run_v, max_run_v;
  logic          last_gnt;

  function automatic logic [DW-1:0] ref_rd(input int a);
    logic [31:0] t;
    t = a;
    return ref_mem.exists(a) ? ref_mem[a] : t[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_vv.delete(); exp_vd.delete(); exp_fv.delete(); exp_fd.delete();
    hold_v = '0; hold_f = '0;
    e_addr = '0; e_we = 1'b0; e_wdata = '0;
    e_wait = 0; e_vrd = 0;
  endtask

  task automatic cycle(input bit vr, input logic [AW-1:0] va, input bit fr, input bit fw,
                       input logic [AW-1:0] fa, input logic [DW-1:0] fd);
    bit ev, ef;
    @(negedge clk);
    vga_req = vr; vga_addr = va; flt_req = fr; flt_we = fw; flt_addr = fa; flt_wdata = fd;
`ifdef FB_ARB_STATS_EN
    stat_clr = stat_clr_drv;
`endif
    #1;
    last_gnt = flt_gnt;
    chk("flt_gnt", flt_gnt, fr & ~vr);
    ev = exp_vv.exists(cyc);
    if (ev) begin hold_v = exp_vd[cyc]; exp_vv.delete(cyc); end
    ef = exp_fv.exists(cyc);
    if (ef) begin hold_f = exp_fd[cyc]; exp_fv.delete(cyc); end
    chk("vga_valid", vga_valid, ev);
    chk("vga_data", vga_data, hold_v);
    chk("flt_rvalid", flt_rvalid, ef);
    chk("flt_rdata", flt_rdata, hold_f);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
`ifdef FB_ARB_STATS_EN
    chk("stat_flt_wait", stat_flt_wait, e_wait);
    chk("stat_vga_reads", stat_vga_reads, e_vrd);
`endif
    if (vga_valid === 1'b1) begin pulses_v++; run_v++; end else run_v = 0;
    if (run_v > max_run_v) max_run_v = run_v;
    if (flt_rvalid === 1'b1) pulses_f++;
    if (mem_we === 1'b1) pulses_we++;
    if (flt_gnt === 1'b1) gnts++;
    // accept this cycle's request
    e_we = 1'b0;
    if (vr) begin
      exp_vv[cyc + LAT] = 1'b1;
      exp_vd[cyc + LAT] = ref_rd(int'(va));
      e_addr = va;
    end else if (fr) begin
      e_addr = fa;
      if (fw) begin
        ref_mem[int'(fa)] = fd;
        e_we = 1'b1;
        e_wdata = fd;
      end else begin
        exp_fv[cyc + LAT] = 1'b1;
        exp_fd[cyc + LAT] = ref_rd(int'(fa));
      end
    end
    if (stat_clr_drv) begin
      e_wait = 0; e_vrd = 0;
    end else begin
      if (fr && vr && e_wait < 65535) e_wait++;
      if (vr && e_vrd < 65535) e_vrd++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Asserts reset mid-cycle with a filter request pending; everything must drop at once.
  task automatic do_reset();
    @(negedge clk);
    vga_req = 1'b0; flt_req = 1'b1; flt_we = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_flt_gnt", flt_gnt, 1'b0);
    chk("rst_vga_valid", vga_valid, 1'b0);
    chk("rst_vga_data", vga_data, '0);
    chk("rst_flt_rvalid", flt_rvalid, 1'b0);
    chk("rst_flt_rdata", flt_rdata, '0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wdata", mem_wdata, '0);
`ifdef FB_ARB_STATS_EN
    chk("rst_stat_wait", stat_flt_wait, '0);
    chk("rst_stat_vrd", stat_vga_reads, '0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    flt_req = 1'b0;
    reset = 1'b1;
    model_clear();
  endtask

  typedef struct {
    bit vr;
    bit fr;
    bit fw;
    bit gnt;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int p0, p1, w0, g0;
    bit f_pend, f_we;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_wd;
    logic [AW-1:0] va;
    bit vr;

    n_cmp = 0; n_bad = 0; cyc = 0;
    pulses_v = 0; pulses_f = 0; pulses_we = 0; gnts = 0; run_v = 0; max_run_v = 0;
    stat_clr_drv = 1'b0;
    reset = 1'b0;
    vga_req = 1'b0; vga_addr = '0; flt_req = 1'b0; flt_we = 1'b0; flt_addr = '0; flt_wdata = '0;
`ifdef FB_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    model_clear();
    do_reset();

    // grant rule table: {vga_req, flt_req, flt_we} -> flt_gnt
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0};
    tbl[2] = '{0, 1, 0, 1};
    tbl[3] = '{0, 1, 1, 1};
    tbl[4] = '{1, 0, 0, 0};
    tbl[5] = '{1, 0, 1, 0};
    tbl[6] = '{1, 1, 0, 0};
    tbl[7] = '{1, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].vr, AW'(100 + i), tbl[i].fr, tbl[i].fw, AW'(200 + i), DW'(8'h30 + i));
      chk("tbl_gnt", last_gnt, tbl[i].gnt);
    end
    idle(3);

    // continuous display fetch 0..639
    p0 = pulses_v; g0 = gnts; max_run_v = 0;
    for (int a = 0; a < 640; a++) cycle(1'b1, AW'(a), 1'b0, 1'b0, '0, '0);
    idle(3);
    chk("vga_burst_count", pulses_v - p0, 640);
    chk("vga_burst_run", max_run_v, 640);
    chk("vga_burst_nognt", gnts - g0, 0);

    // filter write then back-to-back read of the same address
    w0 = pulses_we; p1 = pulses_f; g0 = gnts;
    cycle(1'b0, '0, 1'b1, 1'b1, 19'h12345, 8'hA5);
    cycle(1'b0, '0, 1'b1, 1'b0, 19'h12345, 8'h00);
    idle(3);
    chk("wr_we_pulses", pulses_we - w0, 1);
    chk("rd_rvalid_pulses", pulses_f - p1, 1);
    chk("rd_gnts", gnts - g0, 2);
    chk("rd_data_a5", flt_rdata, 8'hA5);

    // filter read held under 10 display cycles
    p0 = pulses_v; p1 = pulses_f; g0 = gnts;
    for (int i = 0; i < 10; i++) cycle(1'b1, AW'(300 + i), 1'b1, 1'b0, 19'h00777, '0);
    chk("blocked_no_gnt", gnts - g0, 0);
    cycle(1'b0, '0, 1'b1, 1'b0, 19'h00777, '0);
    chk("blocked_then_gnt", last_gnt, 1'b1);
    idle(3);
    chk("blocked_vga_pulses", pulses_v - p0, 10);
    chk("blocked_flt_pulses", pulses_f - p1, 1);

    // alternating owners back-to-back
    p0 = pulses_v; p1 = pulses_f;
    cycle(1'b1, 19'd1, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, 19'd2, '0);
    cycle(1'b1, 19'd3, 1'b0, 1'b0, '0, '0);
    idle(3);
    chk("alt_vga_pulses", pulses_v - p0, 2);
    chk("alt_flt_pulses", pulses_f - p1, 1);
    chk("alt_vga_last", vga_data, 8'h03);
    chk("alt_flt_last", flt_rdata, 8'h02);

    // reset one cycle after a read grant
    p0 = pulses_v; p1 = pulses_f;
    cycle(1'b0, '0, 1'b1, 1'b0, 19'h00042, '0);
    do_reset();
    idle(5);
    chk("rst_no_flt_pulse", pulses_f - p1, 0);
    chk("rst_no_vga_pulse", pulses_v - p0, 0);

`ifdef FB_ARB_STATS_EN
    stat_clr_drv = 1'b1;
    idle(1);
    stat_clr_drv = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b1, AW'(i), 1'b1, 1'b0, 19'h00055, '0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("stat_wait_5", stat_flt_wait, 16'd5);
    stat_clr_drv = 1'b1;
    cycle(1'b1, 19'd9, 1'b1, 1'b0, 19'h00055, '0);
    stat_clr_drv = 1'b0;
    cycle(1'b0, '0, 1'b1, 1'b0, 19'h00055, '0);
    chk("stat_clr_wins", stat_flt_wait, 16'd0);
    idle(3);
`endif

    // randomized traffic with the filter holding its request until granted
    f_pend = 1'b0; f_we = 1'b0; f_addr = '0; f_wd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1'b1;
        f_we   = 1'($urandom_range(0, 1));
        f_addr = AW'($urandom_range(0, 15));
        f_wd   = DW'($urandom);
      end
      vr = 1'($urandom_range(0, 1));
      va = AW'($urandom_range(0, 15));
      stat_clr_drv = ($urandom_range(0, 31) == 0);
      cycle(vr, va, f_pend, f_we, f_addr, f_wd);
      if (f_pend && !vr) f_pend = 1'b0;
    end
    stat_clr_drv = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
